// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, start-bit qualification at mid-bit,
// centre sampling of LSB-first data and stop-bit check, all paced by the oversample tick.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] SMid  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SEnd  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLast = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q;

    // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            b_cnt_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            b_cnt_q <= b_cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        b_cnt_d = b_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d = StStart;
                        s_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (s_cnt_q == SMid) begin
                        if (!rx_s_q) begin
                            state_d = StData;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
                StData: begin
                    if (s_cnt_q == SEnd) begin
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        b_cnt_d = b_cnt_q + BW'(1);
                        if (b_cnt_q == BLast) begin
                            state_d = StStop;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
                StStop: begin
                    // Returning to idle mid-stop-bit lets a back-to-back start edge be caught.
                    if (s_cnt_q == SEnd) begin
                        state_d = StIdle;
                        if (rx_s_q) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8-bit/16x instance and a 7-bit instance, tick every 4 clk.
module tb_uart_rx;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       tick_en;
    logic [1:0] tdiv = 2'd0;
    logic       line;
    logic       sel;
    logic       rx8, rx7;
    int         cyc = 0;

    logic [7:0] rx_data8;
    logic       rx_valid8, frame_err8, busy8;
    logic [6:0] rx_data7;
    logic       rx_valid7, frame_err7, busy7;

    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    int   vtimes[$];
    int   checks = 0;
    int   errors = 0;

    assign rx8 = sel ? 1'b1 : line;
    assign rx7 = sel ? line : 1'b1;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rx       (rx8),
        .rx_data  (rx_data8),
        .rx_valid (rx_valid8),
        .frame_err(frame_err8),
        .busy     (busy8)
    );

    uart_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rx       (rx7),
        .rx_data  (rx_data7),
        .rx_valid (rx_valid7),
        .frame_err(frame_err7),
        .busy     (busy7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tdiv <= tdiv + 2'd1;
        tick <= tick_en && (tdiv == 2'd3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each iteration ends on the negedge just before a tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            @(negedge clk);
            while (!tick && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int nbits, input logic stop);
        line = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            line = d[i];
            wait_ticks(16);
        end
        line = stop;
        wait_ticks(16);
        line = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_valid8 || frame_err8)) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb8_unexpected: valid=%b ferr=%b data=0x%0h, expected no pulse",
                         rx_valid8, frame_err8, rx_data8);
            end else begin
                e8 = q8.pop_front();
                chk("sb8_event", {22'd0, rx_valid8, frame_err8, rx_data8},
                    {22'd0, !e8.err, e8.err, e8.data});
            end
            if (rx_valid8) vtimes.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst && (rx_valid7 || frame_err7)) begin
            if (q7.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb7_unexpected: valid=%b ferr=%b data=0x%0h, expected no pulse",
                         rx_valid7, frame_err7, rx_data7);
            end else begin
                e7 = q7.pop_front();
                chk("sb7_event", {22'd0, rx_valid7, frame_err7, 1'b0, rx_data7},
                    {22'd0, !e7.err, e7.err, e7.data});
            end
        end
    end

    initial begin
        logic [7:0] part;
        rst     = 1'b1;
        line    = 1'b1;
        sel     = 1'b0;
        tick_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {21'd0, rx_data8, rx_valid8, frame_err8, busy8}, 32'd0);
        chk("reset_outputs7", {22'd0, rx_data7, rx_valid7, frame_err7, busy7}, 32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // Single byte
        q8.push_back('{err: 1'b0, data: 8'h55});
        send_byte(8'h55, 8, 1'b1);
        wait_ticks(20);
        chk("idle_busy_low", {31'd0, busy8}, 32'd0);

        // Back-to-back frames, exactly 160 ticks * 4 clk apart
        q8.push_back('{err: 1'b0, data: 8'h00});
        q8.push_back('{err: 1'b0, data: 8'hFF});
        send_byte(8'h00, 8, 1'b1);
        send_byte(8'hFF, 8, 1'b1);
        wait_ticks(20);
        if (vtimes.size() >= 3) chk("b2b_spacing", vtimes[2] - vtimes[1], 32'd640);
        else chk("b2b_pulse_count", vtimes.size(), 32'd3);

        // Framing error keeps the last good byte
        q8.push_back('{err: 1'b0, data: 8'h3C});
        send_byte(8'h3C, 8, 1'b1);
        q8.push_back('{err: 1'b1, data: 8'h3C});
        send_byte(8'hA3, 8, 1'b0);
        wait_ticks(40);
        chk("ferr_data_held", {24'd0, rx_data8}, 32'h3C);

        // Glitch shorter than half a bit
        line = 1'b0;
        wait_ticks(4);
        chk("glitch_busy_high", {31'd0, busy8}, 32'd1);
        line = 1'b1;
        wait_ticks(12);
        chk("glitch_busy_low", {31'd0, busy8}, 32'd0);
        q8.push_back('{err: 1'b0, data: 8'h81});
        send_byte(8'h81, 8, 1'b1);
        wait_ticks(20);

        // Reset after four data bits of 0xF0
        part = 8'hF0;
        line = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            line = part[i];
            wait_ticks(16);
        end
        chk("midframe_busy", {31'd0, busy8}, 32'd1);
        rst  = 1'b1;
        line = 1'b1;
        @(negedge clk);
        chk("midframe_reset_outputs", {21'd0, rx_data8, rx_valid8, frame_err8, busy8}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(20);
        q8.push_back('{err: 1'b0, data: 8'h5A});
        send_byte(8'h5A, 8, 1'b1);
        wait_ticks(20);
        chk("post_reset_data", {24'd0, rx_data8}, 32'h5A);

        // Tick held low for 1000 clk in the middle of data bit 3
        q8.push_back('{err: 1'b0, data: 8'hC3});
        fork
            send_byte(8'hC3, 8, 1'b1);
            begin
                wait_ticks(16 * 4 + 5);
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                chk("gated_busy", {31'd0, busy8}, 32'd1);
                tick_en = 1'b1;
            end
        join
        wait_ticks(20);

        // Seven data bits
        sel = 1'b1;
        q7.push_back('{err: 1'b0, data: 8'h4B});
        send_byte(8'h4B, 7, 1'b1);
        wait_ticks(20);
        sel = 1'b0;
        chk("dut7_data", {25'd0, rx_data7}, 32'h4B);

        chk("sb8_drained", q8.size(), 32'd0);
        chk("sb7_drained", q7.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
